silu_req_arbiter: RTL and testbench
===================================

Name: silu_req_arbiter

Overview:
- Shares one combinational `silu` instance (FP32, I_EXP/I_MNT configurable) between NUM_REQ streaming requesters in the vector engine activation stage.
- Round-robin arbitration at burst granularity. A grant is held from the first beat until `req_last`.
- Each result is registered into a single output stage carrying the requester ID, so downstream logic can route it.
- Supports back-pressure on the output side.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(NUM_REQ).
- I_EXP, 8, exponent width passed to `silu`.
- I_MNT, 23, mantissa width passed to `silu`.
- I_DATA, 32, data width = I_EXP+I_MNT+1.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- req_valid  in  NUM_REQ  per-requester beat valid
- req_ready  out  NUM_REQ  per-requester beat accept
- req_data  in  NUM_REQ*I_DATA  packed operands; requester i occupies [i*I_DATA +: I_DATA]
- req_last  in  NUM_REQ  final beat of the burst
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  I_DATA  silu(operand)
- out_id  out  ID_W  source requester
- out_last  out  1  copy of req_last for this beat
- busy  out  1  arbiter in BURST or output holding data

Behaviour:
- Reset values (async, rst_n=0):
  - out_valid=0, out_data=0, out_id=0, out_last=0, req_ready=0, busy=0.
  - state=IDLE, last_grant=NUM_REQ-1, so requester 0 has first priority.
- State IDLE:
  - req_ready=0.
  - If any req_valid is high, select the first valid index searching upward from last_grant+1 (with wrap) and register it as grant.
  - Next cycle the state is BURST. This gives one arbitration bubble per burst.
- State BURST:
  - req_ready[grant] = !out_valid || out_ready. All other req_ready bits are 0.
  - A beat transfers when req_valid[grant] && req_ready[grant].
  - On a transfer: out_data <= silu(req_data[grant]), out_id <= grant, out_last <= req_last[grant], out_valid <= 1.
  - A transfer with req_last=1 sets last_grant <= grant and returns the state to IDLE.
- Latency and throughput:
  - A beat accepted in cycle N appears on the output in cycle N+1.
  - Throughput is one beat per cycle within a burst.
- Output stage:
  - When out_valid && out_ready and no new transfer occurs in the same cycle, out_valid <= 0.
  - While out_valid && !out_ready, out_data, out_id and out_last hold stable and req_ready=0.
  - A simultaneous pop and transfer loads the new beat with no bubble.
- Idle requester inside a burst: if the granted requester drops req_valid mid-burst, the grant is held indefinitely (no timeout). Other requesters stall.
- A requester that is not granted may hold req_valid high; it never sees req_ready.
- busy = (state==BURST) || out_valid.
- Reset mid-burst clears all state. A partially transferred burst is discarded, and requesters must restart it.
- Arithmetic: values pass through `silu` unmodified, including special-case handling (zero, ±Inf, NaN, saturation regions). No rounding is added in this block.

Optional Feature:
- Macro: ACT_SPECIAL_CNT_EN.
- Enabled:
  - Adds output port `special_cnt` (16 bits) and input `special_clr` (1 bit).
  - `special_cnt` is a saturating count of transferred beats whose operand exponent is all-ones (Inf or NaN).
  - Reset value is 0. It saturates at 16'hFFFF.
  - special_clr=1 zeroes the counter; clear takes priority over a same-cycle increment.
- Disabled: neither port exists, and the counter logic is absent.

Test Plan:
- Single beat:
  - Stimulus: req0 sends 0x41000000, last=1, with out_ready=1.
  - Response: req_ready[0] goes high in the cycle after req_valid[0] first rises. out_valid rises one cycle after the transfer with out_data=0x41000000, out_id=0, out_last=1. busy falls after the pop.
- Round-robin:
  - Stimulus: all 4 requesters continuously issue single-beat bursts (4.0=0x40800000).
  - Response: out_id sequence is 0,1,2,3,0,1. Each grant is separated by one bubble cycle.
- Burst lock:
  - Stimulus: req1 sends a 3-beat burst (0x41000000, 0xC1000000, 0x7F800000). req0 asserts valid during beat 2.
  - Response: outputs are 0x41000000, 0x00000000, 0x7F800000, all with id=1, and last is set only on beat 3. req0 is granted next.
- Back-pressure:
  - Stimulus: out_ready held 0 for 3 cycles during a 4-beat burst.
  - Response: out_data/out_id stay constant and req_ready[grant]=0 throughout. When out_ready returns to 1, beats resume with no loss or duplication.
- Reset mid-burst:
  - Stimulus: assert rst_n=0 after beat 2 of 4.
  - Response: out_valid, req_ready and busy go to 0 immediately (async). After release, req0 gets priority first.
- With ACT_SPECIAL_CNT_EN:
  - Stimulus: send 0x7FC00000, 0xFF800000, 0x00000000.
  - Response: special_cnt=2, and out_data=NaN for the first beat. Pulsing special_clr sets special_cnt to 0.

Source files
------------

// File: rtl/silu_req_arbiter.sv
// Round-robin, burst-locked sharing of one combinational silu between NUM_REQ requesters.
// Optional saturating Inf/NaN beat counter under `ifdef ACT_SPECIAL_CNT_EN.

// Combinational silu: specials and saturation regions exact, mid-range a power-of-two
// approximation of x*sigmoid(x) done by exponent decrement (subnormal results flush to zero).
module silu #(
  parameter int I_EXP  = 8,
  parameter int I_MNT  = 23,
  parameter int I_DATA = 32
) (
  input  logic [I_DATA-1:0] x,
  output logic [I_DATA-1:0] y
);
  localparam logic [I_EXP-1:0] BIAS = {1'b0, {(I_EXP-1){1'b1}}};

  logic             s;
  logic [I_EXP-1:0] e;
  logic [I_EXP-1:0] sh;
  logic [I_MNT-1:0] m;

  assign s = x[I_DATA-1];
  assign e = x[I_MNT +: I_EXP];
  assign m = x[I_MNT-1:0];

  always_comb begin
    y  = x;
    sh = '0;
    if (e == '1) begin
      if (m == '0 && s) y = '0;
    end else if (e == '0) begin
      y = x;
    end else if (!s) begin
      if (e < BIAS) sh = I_EXP'(1);
    end else if (e >= BIAS + I_EXP'(3)) begin
      y = '0;
    end else if (e >= BIAS + I_EXP'(2)) begin
      sh = I_EXP'(7);
    end else if (e >= BIAS + I_EXP'(1)) begin
      sh = I_EXP'(4);
    end else if (e >= BIAS) begin
      sh = I_EXP'(2);
    end else begin
      sh = I_EXP'(1);
    end
    if (sh != '0) begin
      if (e <= sh) y = {s, {(I_DATA-1){1'b0}}};
      else         y = {s, e - sh, m};
    end
  end
endmodule

module silu_req_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int I_EXP   = 8,
  parameter int I_MNT   = 23,
  parameter int I_DATA  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*I_DATA-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [I_DATA-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  output logic                      out_last,
  output logic                      busy
`ifdef ACT_SPECIAL_CNT_EN
  ,
  output logic [15:0]               special_cnt,
  input  logic                      special_clr
`endif
);
  typedef enum logic {IDLE, BURST} state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   grant, grant_nxt, last_grant, last_grant_nxt;
  logic [ID_W-1:0]   pick, cand;
  logic              any_valid, xfer;
  int unsigned       idx;
  logic [I_DATA-1:0] sel_data, silu_y;

  // Walk downward so the final overwrite is the nearest valid index above last_grant.
  always_comb begin
    pick      = last_grant;
    any_valid = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int unsigned k = NUM_REQ; k >= 1; k--) begin
      idx  = (32'(last_grant) + k) % NUM_REQ;
      cand = ID_W'(idx);
      if (req_valid[cand]) begin
        pick      = cand;
        any_valid = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= ID_W'(NUM_REQ-1);
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    case (state)
      IDLE: if (any_valid) begin
        grant_nxt = pick;
        state_nxt = BURST;
      end
      BURST: if (xfer && req_last[grant]) begin
        last_grant_nxt = grant;
        state_nxt      = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (state == BURST) req_ready[grant] = !out_valid || out_ready;
  end

  assign xfer     = (state == BURST) && req_valid[grant] && req_ready[grant];
  assign sel_data = req_data[grant*I_DATA +: I_DATA];
  assign busy     = (state == BURST) || out_valid;

  silu #(.I_EXP(I_EXP), .I_MNT(I_MNT), .I_DATA(I_DATA)) u_silu (
    .x(sel_data),
    .y(silu_y)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_id    <= '0;
      out_last  <= 1'b0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= silu_y;
      out_id    <= grant;
      out_last  <= req_last[grant];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef ACT_SPECIAL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      special_cnt <= '0;
    else if (special_clr)
      special_cnt <= '0;
    else if (xfer && sel_data[I_MNT +: I_EXP] == '1 && special_cnt != '1)
      special_cnt <= special_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_silu_req_arbiter.sv
// Directed bench for silu_req_arbiter; exercises the special counter when ACT_SPECIAL_CNT_EN is defined.
module tb_silu_req_arbiter;
  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid, req_ready, req_last;
  logic [127:0] req_data;
  logic         out_valid, out_ready, out_last, busy;
  logic [31:0]  out_data;
  logic [1:0]   out_id;
`ifdef ACT_SPECIAL_CNT_EN
  logic [15:0]  special_cnt;
  logic         special_clr;
`endif

  int checks = 0;
  int errors = 0;
  int n, last_c, bi, popped;
  logic [1:0]  rr_exp [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  logic [31:0] bp [4]     = '{32'h41000000, 32'h41100000, 32'h41200000, 32'h41300000};

  always #5 clk = ~clk;

  silu_req_arbiter #(.NUM_REQ(4), .ID_W(2), .I_EXP(8), .I_MNT(23), .I_DATA(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data), .req_last(req_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_id(out_id),
    .out_last(out_last), .busy(busy)
`ifdef ACT_SPECIAL_CNT_EN
    , .special_cnt(special_cnt), .special_clr(special_clr)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [31:0] v);
    req_data[i*32 +: 32] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_valid = '0; req_last = '0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; out_ready = 1'b1;
`ifdef ACT_SPECIAL_CNT_EN
    special_clr = 1'b0;
`endif
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;

    // single beat
    @(negedge clk);
    set_data(0, 32'h41000000); req_last = 4'b0001; req_valid = 4'b0001;
    #1 chk("t1_ready_idle", req_ready, 0);
    @(negedge clk);
    chk("t1_ready_burst", req_ready, 4'b0001);
    chk("t1_busy_burst", busy, 1);
    @(negedge clk);
    req_valid = '0;
    chk("t1_out_valid", out_valid, 1);
    chk("t1_out_data", out_data, 32'h41000000);
    chk("t1_out_id", out_id, 0);
    chk("t1_out_last", out_last, 1);
    chk("t1_ready_bubble", req_ready, 0);
    @(negedge clk);
    chk("t1_out_valid_pop", out_valid, 0);
    chk("t1_busy_pop", busy, 0);

    // round-robin
    do_reset();
    for (int i = 0; i < 4; i++) set_data(i, 32'h40800000);
    req_last = 4'b1111; req_valid = 4'b1111;
    n = 0; last_c = 0;
    for (int c = 0; c < 30 && n < 6; c++) begin
      @(negedge clk);
      if (out_valid) begin
        chk("t2_id", out_id, rr_exp[n]);
        chk("t2_data", out_data, 32'h40800000);
        if (n > 0) chk("t2_gap", c - last_c, 2);
        last_c = c;
        n++;
      end
    end
    chk("t2_count", n, 6);
    req_valid = '0;

    // burst lock
    do_reset();
    set_data(1, 32'h41000000); req_last = 4'b0000; req_valid = 4'b0010;
    @(negedge clk);
    chk("t3_ready_b1", req_ready, 4'b0010);
    @(negedge clk);
    chk("t3_data_b1", out_data, 32'h41000000);
    chk("t3_id_b1", out_id, 1);
    chk("t3_last_b1", out_last, 0);
    set_data(1, 32'hC1000000);
    set_data(0, 32'h3F800000); req_last = 4'b0001; req_valid = 4'b0011;
    #1 chk("t3_ready_lock", req_ready, 4'b0010);
    @(negedge clk);
    chk("t3_data_b2", out_data, 32'h00000000);
    chk("t3_id_b2", out_id, 1);
    chk("t3_last_b2", out_last, 0);
    set_data(1, 32'h7F800000); req_last = 4'b0011;
    @(negedge clk);
    chk("t3_data_b3", out_data, 32'h7F800000);
    chk("t3_id_b3", out_id, 1);
    chk("t3_last_b3", out_last, 1);
    req_valid = 4'b0001;
    @(negedge clk);
    chk("t3_ready_req0", req_ready, 4'b0001);
    @(negedge clk);
    req_valid = '0;
    chk("t3_id_req0", out_id, 0);
    chk("t3_data_req0", out_data, 32'h3F800000);

    // back-pressure
    do_reset();
    req_valid = 4'b0100;
    bi = 0; popped = 0;
    for (int c = 0; c < 30 && popped < 4; c++) begin
      @(negedge clk);
      out_ready = !(c >= 2 && c <= 4);
      if (bi < 4) begin
        set_data(2, bp[bi]);
        req_last = (bi == 3) ? 4'b0100 : 4'b0000;
      end else begin
        req_valid = '0; req_last = '0;
      end
      #1;
      if (out_valid) begin
        chk("t4_data", out_data, bp[popped]);
        chk("t4_id", out_id, 2);
        chk("t4_last", out_last, (popped == 3) ? 1 : 0);
        if (!out_ready) chk("t4_stall_ready", req_ready, 0);
        else popped++;
      end
      if (req_valid[2] && req_ready[2]) bi++;
    end
    chk("t4_popped", popped, 4);
    chk("t4_sent", bi, 4);
    out_ready = 1'b1;
    @(negedge clk);
    chk("t4_no_dup", out_valid, 0);
    chk("t4_busy_end", busy, 0);

    // reset mid-burst
    do_reset();
    set_data(1, 32'h41000000); req_last = '0; req_valid = 4'b0010;
    @(negedge clk);
    chk("t5_ready_b1", req_ready, 4'b0010);
    @(negedge clk);
    @(negedge clk);
    chk("t5_valid_b2", out_valid, 1);
    rst_n = 1'b0; req_valid = 4'b1011;
    #1;
    chk("t5_rst_out_valid", out_valid, 0);
    chk("t5_rst_ready", req_ready, 0);
    chk("t5_rst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_prio_req0", req_ready, 4'b0001);
    req_valid = '0;

`ifdef ACT_SPECIAL_CNT_EN
    do_reset();
    set_data(0, 32'h7FC00000); req_last = '0; req_valid = 4'b0001;
    @(negedge clk);
    @(negedge clk);
    chk("t6_nan", out_data, 32'h7FC00000);
    set_data(0, 32'hFF800000);
    @(negedge clk);
    chk("t6_ninf", out_data, 32'h00000000);
    set_data(0, 32'h00000000); req_last = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    chk("t6_zero", out_data, 32'h00000000);
    chk("t6_cnt", special_cnt, 2);
    special_clr = 1'b1;
    @(negedge clk);
    special_clr = 1'b0;
    chk("t6_clr", special_cnt, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
